// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcodes, funct7 constants and instruction classes shared by the encoder and control unit
package riscv_pkg;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;
  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_L, CLS_JALR, CLS_B, CLS_S, CLS_JAL, CLS_LUI, CLS_AUIPC
  } instr_class_t;
  // true when v is representable as a bits-wide two's-complement value
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] s;
    s = 32'($signed(v) >>> (bits - 1));
    return s == '0 || s == '1;
  endfunction
endpackage

// File: rtl/instr_encoder_pack.sv
// instr_pack: combinational RV32I field packer and immediate/funct3 legality check
// Ports: cls/funct3/alt/rd/rs1/rs2/imm decoded fields in; inst packed word, illegal flag out.
module instr_pack
  import riscv_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [2:0]  funct3,
  input  logic        alt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        illegal
);
  logic shift;
  assign shift = funct3 == 3'b001 || funct3 == 3'b101;
  always_comb begin
    inst = '0;
    illegal = 1'b0;
    case (cls)
      CLS_R: inst = {alt ? F7_ALT : F7_BASE, rs2, rs1, funct3, rd, OP_R};
      CLS_I: begin
        // only SRAI takes the alternate funct7; SLLI always uses the base pattern
        inst = shift ? {(alt && funct3 == 3'b101) ? F7_ALT : F7_BASE, imm[4:0], rs1, funct3, rd, OP_I}
                     : {imm[11:0], rs1, funct3, rd, OP_I};
        illegal = shift ? imm[31:5] != '0 : !fits_signed(imm, 12);
      end
      CLS_L: begin
        inst = {imm[11:0], rs1, funct3, rd, OP_L};
        illegal = !fits_signed(imm, 12) || !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      CLS_JALR: begin
        inst = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
        illegal = !fits_signed(imm, 12);
      end
      CLS_S: begin
        inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S};
        illegal = !fits_signed(imm, 12) || funct3 > 3'b010;
      end
      CLS_B: begin
        inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_B};
        illegal = !fits_signed(imm, 13) || imm[0] || funct3 inside {3'b010, 3'b011};
      end
      CLS_JAL: begin
        inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        illegal = !fits_signed(imm, 21) || imm[0];
      end
      CLS_LUI, CLS_AUIPC: begin
        inst = {imm[31:12], rd, cls == CLS_LUI ? OP_LUI : OP_AUIPC};
        illegal = imm[11:0] != '0;
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: registers packed RV32I words with target byte addresses on a valid/ready stream
// Ports: clk/rst; in_* request stream with decoded fields; clr soft clear;
//        out_* word stream (inst, addr); err_valid pulse and saturating err_count.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_class,
  input  logic [2:0]  in_funct3,
  input  logic        in_alt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  input  logic        clr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        err_valid,
  output logic [7:0]  err_count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] addr_q;
  logic [31:0]   inst;
  logic          illegal, accept, emit;
  instr_pack u_pack (
    .cls(in_class), .funct3(in_funct3), .alt(in_alt), .rd(in_rd), .rs1(in_rs1),
    .rs2(in_rs2), .imm(in_imm), .inst(inst), .illegal(illegal)
  );
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign emit     = out_valid && out_ready;
  // DEPTH is a power of two, so the index wraps to zero by overflow
  assign out_addr = BASE_ADDR + 32'({addr_q, 2'b00});
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      addr_q    <= '0;
      err_valid <= 1'b0;
      err_count <= '0;
    end else begin
      out_valid <= (accept && !illegal) || (out_valid && !out_ready);
      if (accept && !illegal) out_inst <= inst;
      if (emit) addr_q <= addr_q + AW'(1);
      err_valid <= accept && illegal;
      if (accept && illegal && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: vector table plus scoreboard bench for instr_encoder
module tb_instr_encoder;
  import riscv_pkg::*;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int DEPTH = 4;
  logic clk, rst, clr, in_valid, in_ready, in_alt, out_valid, out_ready, err_valid;
  logic [3:0] in_class;
  logic [2:0] in_funct3;
  logic [4:0] in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_inst, out_addr;
  logic [7:0] err_count;
  instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
    .in_funct3(in_funct3), .in_alt(in_alt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .clr(clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .err_valid(err_valid), .err_count(err_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] cls; logic [2:0] f3; logic alt; logic [4:0] rd, rs1, rs2;
    logic [31:0] imm; logic [31:0] inst; logic bad;
  } vec_t;
  typedef struct { logic [31:0] inst; logic [31:0] addr; } exp_t;
  vec_t vecs[21];
  exp_t sb[$];
  int checks = 0, errors = 0, idx = 0, exp_err = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (out_valid && out_ready && !rst && !clr) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_word got %h expected none", out_inst);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_inst", out_inst, e.inst);
        chk("out_addr", out_addr, e.addr);
      end
    end
  end
  task automatic drive(input vec_t v);
    in_class = v.cls; in_funct3 = v.f3; in_alt = v.alt;
    in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
    in_valid = 1'b1;
  endtask
  task automatic send(input vec_t v);
    int n;
    drive(v);
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got in_ready=0 expected 1");
      @(posedge clk); #1;
      in_valid = 1'b0;
      return;
    end
    if (!v.bad) begin
      sb.push_back('{v.inst, BASE + 32'(4 * (idx % DEPTH))});
      idx++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (v.bad) begin
      exp_err = exp_err < 255 ? exp_err + 1 : 255;
      chk("err_valid", err_valid, 1);
      chk("err_count", err_count, exp_err);
    end else chk("err_valid_idle", err_valid, 0);
  endtask
  task automatic drain();
    for (int n = 0; n < 20 && sb.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    chk("drain_left", sb.size(), 0);
  endtask
  task automatic check_cleared(input string name);
    chk({name, "_out_valid"}, out_valid, 0);
    chk({name, "_out_inst"}, out_inst, 0);
    chk({name, "_out_addr"}, out_addr, BASE);
    chk({name, "_err_valid"}, err_valid, 0);
    chk({name, "_err_count"}, err_count, 0);
    chk({name, "_in_ready"}, in_ready, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] held_addr;
    vecs[0]  = '{CLS_R,     3'b000, 1'b0, 5'd3,  5'd1, 5'd2, 32'd0,          32'h002081B3, 1'b0};
    vecs[1]  = '{CLS_R,     3'b000, 1'b1, 5'd5,  5'd6, 5'd7, 32'd0,          32'h407302B3, 1'b0};
    vecs[2]  = '{CLS_I,     3'b000, 1'b0, 5'd1,  5'd0, 5'd0, 32'hFFFF_FFFF,  32'hFFF00093, 1'b0};
    vecs[3]  = '{CLS_I,     3'b000, 1'b0, 5'd1,  5'd0, 5'd0, 32'd2048,       32'h0,        1'b1};
    vecs[4]  = '{CLS_B,     3'b000, 1'b0, 5'd0,  5'd0, 5'd0, 32'd8,          32'h00000463, 1'b0};
    vecs[5]  = '{CLS_JAL,   3'b000, 1'b0, 5'd1,  5'd0, 5'd0, 32'd2048,       32'h001000EF, 1'b0};
    vecs[6]  = '{CLS_LUI,   3'b000, 1'b0, 5'd5,  5'd0, 5'd0, 32'h12345000,   32'h123452B7, 1'b0};
    vecs[7]  = '{CLS_B,     3'b000, 1'b0, 5'd0,  5'd0, 5'd0, 32'd7,          32'h0,        1'b1};
    vecs[8]  = '{CLS_I,     3'b101, 1'b1, 5'd2,  5'd3, 5'd0, 32'd4,          32'h4041D113, 1'b0};
    vecs[9]  = '{CLS_I,     3'b001, 1'b0, 5'd2,  5'd3, 5'd0, 32'd32,         32'h0,        1'b1};
    vecs[10] = '{CLS_S,     3'b010, 1'b0, 5'd0,  5'd2, 5'd5, 32'hFFFF_FFFC,  32'hFE512E23, 1'b0};
    vecs[11] = '{CLS_L,     3'b011, 1'b0, 5'd4,  5'd2, 5'd0, 32'd8,          32'h0,        1'b1};
    vecs[12] = '{CLS_L,     3'b010, 1'b0, 5'd4,  5'd2, 5'd0, 32'd8,          32'h00812203, 1'b0};
    vecs[13] = '{CLS_JALR,  3'b011, 1'b0, 5'd1,  5'd5, 5'd0, 32'd4,          32'h004280E7, 1'b0};
    vecs[14] = '{CLS_AUIPC, 3'b000, 1'b0, 5'd10, 5'd0, 5'd0, 32'h00001000,   32'h00001517, 1'b0};
    vecs[15] = '{CLS_AUIPC, 3'b000, 1'b0, 5'd10, 5'd0, 5'd0, 32'h00001001,   32'h0,        1'b1};
    vecs[16] = '{CLS_B,     3'b001, 1'b0, 5'd0,  5'd1, 5'd2, 32'hFFFF_FFFC,  32'hFE209EE3, 1'b0};
    vecs[17] = '{CLS_B,     3'b010, 1'b0, 5'd0,  5'd1, 5'd2, 32'd8,          32'h0,        1'b1};
    vecs[18] = '{CLS_JAL,   3'b000, 1'b0, 5'd1,  5'd0, 5'd0, 32'h00100000,   32'h0,        1'b1};
    vecs[19] = '{4'd9,      3'b000, 1'b0, 5'd1,  5'd0, 5'd0, 32'd0,          32'h0,        1'b1};
    vecs[20] = '{CLS_R,     3'b101, 1'b1, 5'd1,  5'd2, 5'd3, 32'd0,          32'h403150B3, 1'b0};
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_class = '0; in_funct3 = '0; in_alt = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_cleared("reset");
    foreach (vecs[i]) send(vecs[i]);
    drain();
    // backpressure: one word parked, next request must stall
    out_ready = 1'b0;
    held_addr = BASE + 32'(4 * (idx % DEPTH));
    send(vecs[0]);
    drive(vecs[1]);
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_inst_hold", out_inst, vecs[0].inst);
      chk("bp_addr_hold", out_addr, held_addr);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(vecs[1]);
    send(vecs[2]);
    send(vecs[4]);
    send(vecs[5]);
    send(vecs[6]);
    drain();
    repeat (256) send(vecs[3]);
    // clr against a pending output handshake and a new request
    out_ready = 1'b0;
    send(vecs[0]);
    clr = 1'b1;
    out_ready = 1'b1;
    drive(vecs[2]);
    @(posedge clk); #1;
    clr = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    idx = 0;
    exp_err = 0;
    check_cleared("clr");
    send(vecs[1]);
    drain();
    // rst mid-stream
    send(vecs[3]);
    send(vecs[0]);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    idx = 0;
    exp_err = 0;
    check_cleared("rst");
    send(vecs[20]);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
